// File: rtl/cross_entropy_grad_inverse_pkg.sv
// Shared definitions for the cross-entropy gradient inverse block:
// fixed-point geometry, the controller state encoding and the output clamp.
package ce_pkg;

   localparam int WIDTH = 16;               // data word, signed two's complement
   localparam int FRAC  = 12;               // fractional bits of a probability
   localparam int ONE   = 1 << FRAC;        // 1.0 in Q.FRAC
   localparam int QBITS = FRAC + 1;         // quotient bits, one per DIV cycle
   localparam int CNT_W = $clog2(QBITS);    // iteration counter width

   typedef logic signed [WIDTH-1:0] data_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DIV   = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   // A probability must stay below 1.0; only d==1 can produce q >= ONE.
   function automatic logic [WIDTH-1:0] sat_prob(input logic [QBITS:0] q);
      if (q >= (QBITS+1)'(ONE))
         sat_prob = WIDTH'(ONE - 1);
      else
         sat_prob = WIDTH'(q);
   endfunction

endpackage

// File: rtl/cross_entropy_grad_inverse_if.sv
// Gradient-in / probability-out stream bundle.
//
// Handshake: both sides use strict valid/ready. A word moves on a rising
// edge where valid and ready are both high. Once valid is raised the source
// holds it and its data stable until that edge; ready may depend on state
// but never on valid in the same cycle. err is meaningful only with
// out_valid.
interface cross_entropy_grad_inverse_if;
   import ce_pkg::*;

   logic  in_valid;
   logic  in_ready;
   data_t in;
   logic  out_valid;
   logic  out_ready;
   data_t out;
   logic  err;

   // Producer of gradients / consumer of probabilities.
   modport master (
      output in_valid, in, out_ready,
      input  in_ready, out_valid, out, err
   );

   // The inverse block itself.
   modport slave (
      input  in_valid, in, out_ready,
      output in_ready, out_valid, out, err
   );

endinterface

// File: rtl/cross_entropy_grad_inverse_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// remainder, subtract the divisor when it fits and report the quotient bit.
module ce_div_step
   import ce_pkg::*;
(
   input  logic [WIDTH:0] r,
   input  logic           bit_in,
   input  logic [WIDTH:0] d,
   output logic [WIDTH:0] r_next,
   output logic           qbit
);

   // r < d <= 2^WIDTH on entry, so the top bit of r is always zero and the
   // shifted value still fits in WIDTH+1 bits.
   logic [WIDTH:0] r_sh;

   // Trial subtraction with restore.
   always_comb begin
      r_sh   = {r[WIDTH-1:0], bit_in};
      qbit   = (r_sh >= d);
      r_next = qbit ? (r_sh - d) : r_sh;
   end

endmodule

// File: rtl/cross_entropy_grad_inverse.sv
// Sequential inverse of the cross-entropy gradient: given g = -ONE/p it
// returns p = floor(ONE/|g|) with a bit-serial restoring divider.
// Optional: CE_INV_ROUND_NEAREST_EN adds a ROUND state that rounds the
// quotient to nearest before saturation.
module cross_entropy_grad_inverse
   import ce_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   cross_entropy_grad_inverse_if.slave bus,
   output state_t                      state_dbg
);

   localparam logic [QBITS-1:0] ONE_Q = QBITS'(ONE);

   state_t             state, state_nxt;
   logic [WIDTH:0]     d_r;        // divisor |g|, one extra bit for -2^(WIDTH-1)
   logic [WIDTH:0]     r_r;        // partial remainder
   logic [QBITS-1:0]   sr_r;       // dividend, consumed MSB first
   logic [QBITS-1:0]   q_r;        // quotient accumulator
   logic [CNT_W-1:0]   cnt;        // remaining DIV iterations minus one
   logic [WIDTH-1:0]   out_r;
   logic               err_r;
   logic               in_ready_c;
   logic               out_valid_c;
   logic               accept;
   logic [WIDTH:0]     r_next;
   logic               qbit;
   logic [QBITS-1:0]   q_shift;

   ce_div_step u_step (
      .r      (r_r),
      .bit_in (sr_r[QBITS-1]),
      .d      (d_r),
      .r_next (r_next),
      .qbit   (qbit)
   );

   assign q_shift       = {q_r[QBITS-2:0], qbit};
   assign accept        = bus.in_valid & in_ready_c;
   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out       = out_r;
   assign bus.err       = err_r;
   assign state_dbg     = state;

   // Controller state register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state and handshake outputs; inputs are only taken in IDLE.
   always_comb begin
      state_nxt   = state;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid)
               state_nxt = bus.in[WIDTH-1] ? DIV : DONE;
         end
         DIV: begin
            if (cnt == '0) begin
`ifdef CE_INV_ROUND_NEAREST_EN
               state_nxt = ROUND;
`else
               state_nxt = DONE;
`endif
            end
         end
         ROUND: state_nxt = DONE;
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Divider datapath and result registers; out/err only change on load.
   always_ff @(posedge clk) begin
      if (reset) begin
         d_r   <= '0;
         r_r   <= '0;
         sr_r  <= '0;
         q_r   <= '0;
         cnt   <= '0;
         out_r <= '0;
         err_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (bus.in[WIDTH-1]) begin
                     d_r   <= -{bus.in[WIDTH-1], bus.in};
                     r_r   <= '0;
                     sr_r  <= ONE_Q;
                     q_r   <= '0;
                     cnt   <= CNT_W'(QBITS - 1);
                     err_r <= 1'b0;
                  end else begin
                     out_r <= '0;
                     err_r <= 1'b1;
                  end
               end
            end
            DIV: begin
               r_r  <= r_next;
               sr_r <= {sr_r[QBITS-2:0], 1'b0};
               q_r  <= q_shift;
               if (cnt != '0)
                  cnt <= cnt - CNT_W'(1);
`ifndef CE_INV_ROUND_NEAREST_EN
               if (cnt == '0)
                  out_r <= sat_prob({1'b0, q_shift});
`endif
            end
`ifdef CE_INV_ROUND_NEAREST_EN
            ROUND: begin
               // Round half up: the fraction is r/d, so compare 2r with d.
               if ({r_r, 1'b0} >= {1'b0, d_r})
                  out_r <= sat_prob({1'b0, q_r} + (QBITS+1)'(1));
               else
                  out_r <= sat_prob({1'b0, q_r});
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cross_entropy_grad_inverse.sv
// Directed bench for cross_entropy_grad_inverse with a reference model,
// expected-result queue and a per-transfer compare process.
// Honours CE_INV_ROUND_NEAREST_EN the same way the design does.
module tb_cross_entropy_grad_inverse;
   import ce_pkg::*;

`ifdef CE_INV_ROUND_NEAREST_EN
   localparam int LAT = QBITS + 2;
`else
   localparam int LAT = QBITS + 1;
`endif
   localparam int W = WIDTH + 1;   // {err, out}

   logic   clk;
   logic   reset;
   state_t state_dbg;
   int     total;
   int     bad;
   logic [W-1:0] exp_q[$];

   cross_entropy_grad_inverse_if bus();

   cross_entropy_grad_inverse dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time exceeded, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // p = ONE/|g| (floor, or nearest when rounding), clamped below ONE.
   function automatic logic [W-1:0] model(input int g);
      int d, q, rem;
      if (g >= 0) return {1'b1, 16'd0};
      d   = -g;
      q   = ONE / d;
      rem = ONE % d;
`ifdef CE_INV_ROUND_NEAREST_EN
      if (2 * rem >= d) q = q + 1;
`endif
      if (q >= ONE) q = ONE - 1;
      return {1'b0, 16'(q)};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   // Every accepted gradient queues its expected result; every output
   // transfer is compared against the oldest entry.
   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("sb_out", int'(bus.out), int'(e[WIDTH-1:0]));
            check("sb_err", int'(bus.err), int'(e[WIDTH]));
         end
      end
      if (!reset && bus.in_valid && bus.in_ready)
         exp_q.push_back(model(int'(bus.in)));
   end

   // ---------------- driver tasks ----------------
   // Present g until accepted; returns during the cycle after acceptance.
   task automatic put(input int g);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in       = 16'(g);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   // Wait for out_valid, report its latency from the accept cycle and the
   // outputs seen at that moment.
   task automatic wait_out(output int lat, output int o, output int e,
                           output bit rdy_seen);
      lat = 0; o = -1; e = -1; rdy_seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         lat = lat + 1;
         if (bus.out_valid) begin
            o = int'(bus.out); e = int'(bus.err);
            return;
         end
         if (bus.in_ready) rdy_seen = 1'b1;
      end
      check("out_valid_timeout", 0, 1);
   endtask

   // Full transaction with out_ready high; checks latency and literal result.
   task automatic run(input string name, input int g, input int exp_lat,
                      input int exp_out, input int exp_err);
      int lat, o, e;
      bit rdy;
      put(g);
      wait_out(lat, o, e, rdy);
      check({name, "_lat"}, lat, exp_lat);
      check({name, "_out"}, o, exp_out);
      check({name, "_err"}, e, exp_err);
      @(posedge clk); #1;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int lat, o, e;
      bit rdy, unstable, rdy_hold;
      total = 0; bad = 0;
      reset = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in        = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready",  int'(bus.in_ready), 1);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out",       int'(bus.out), 0);
      check("rst_err",       int'(bus.err), 0);
      check("rst_state",     int'(state_dbg), int'(IDLE));

      // Pin the model with hand-computed values.
      check("model_m2048",  int'(model(-2048)),  2);
      check("model_m3",     int'(model(-3)),     1365);
      check("model_m1",     int'(model(-1)),     4095);
      check("model_m4096",  int'(model(-4096)),  1);
      check("model_m32768", int'(model(-32768)), 0);
      check("model_m9",     int'(model(-9)),     455);
      check("model_p7",     int'(model(7)),      65536);
`ifdef CE_INV_ROUND_NEAREST_EN
      check("model_m6",     int'(model(-6)),     683);
      check("model_m10",    int'(model(-10)),    410);
`else
      check("model_m6",     int'(model(-6)),     682);
      check("model_m10",    int'(model(-10)),    409);
`endif

      // First transaction: latency and in_ready low during DIV.
      put(-2048);
      wait_out(lat, o, e, rdy);
      check("g2048_lat", lat, LAT);
      check("g2048_out", o, 2);
      check("g2048_err", e, 0);
      check("g2048_in_ready_low", int'(rdy), 0);
      @(posedge clk); #1;

      run("g3", -3, LAT, 1365, 0);
`ifdef CE_INV_ROUND_NEAREST_EN
      run("g6", -6, LAT, 683, 0);
      run("g5000", -5000, LAT, 1, 0);
`else
      run("g6", -6, LAT, 682, 0);
      run("g5000", -5000, LAT, 0, 0);
`endif
      run("g1",     -1,     LAT, 4095, 0);
      run("g4096",  -4096,  LAT, 1, 0);
      run("g32768", -32768, LAT, 0, 0);
      run("g0",     0,      1,   0, 1);
      run("gp7",    7,      1,   0, 1);
      run("g3b",    -3,     LAT, 1365, 0);

      // Backpressure: result held for 20 cycles, new input not taken.
      bus.out_ready = 1'b0;
      put(-10);
      wait_out(lat, o, e, rdy);
      check("bp_lat", lat, LAT);
      unstable = 1'b0; rdy_hold = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in       = -16'sd5;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!bus.out_valid || int'(bus.out) != o || bus.err !== 1'b0)
            unstable = 1'b1;
         if (bus.in_ready) rdy_hold = 1'b1;
      end
`ifdef CE_INV_ROUND_NEAREST_EN
      check("bp_out", o, 410);
`else
      check("bp_out", o, 409);
`endif
      check("bp_stable", int'(unstable), 0);
      check("bp_in_ready_low", int'(rdy_hold), 0);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("bp_after_in_ready",  int'(bus.in_ready), 1);
      check("bp_after_out_valid", int'(bus.out_valid), 0);
      check("bp_queue_empty",     exp_q.size(), 0);

      // Reset during the fifth DIV cycle discards the work in flight.
      put(-9);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_div_out_valid", int'(bus.out_valid), 0);
      check("rst_div_in_ready",  int'(bus.in_ready), 1);
      check("rst_div_state",     int'(state_dbg), int'(IDLE));
      run("g9", -9, LAT, 455, 0);

      repeat (2) @(posedge clk);
      check("final_queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
